// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory / boot loader and the fetch stage.
package inst_mem_loader_pkg;

   localparam int INST_DATA_W = 32;

   // Bubble word the fetch stage injects; also the reset value of read data.
   localparam logic [INST_DATA_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_DATA = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } load_state_e;

endpackage

// File: rtl/inst_bram.sv
// 1R1W synchronous RAM, read-first on address collision. Only the output
// register is reset so the array maps onto block RAM.
module inst_bram #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Write port: registered, no reset on the array.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Read port: samples the pre-write contents, holds when not enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with a UART boot loader: a 4-byte big-endian header gives
// the word count, followed by that many big-endian words written from address 0.
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = INST_DATA_W   // instruction width, fixed at 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_enable,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_data,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              reload,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

   load_state_e       state_q;
   logic [1:0]        byte_cnt_q;
   logic [23:0]       asm_q;
   logic [ADDR_W:0]   hdr_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   words_q;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              done_q;
   logic              err_q;

   logic [31:0]       word_d;
   logic [ADDR_W:0]   words_d;

   // Word completed by the current byte (earlier three bytes are in asm_q).
   assign word_d  = {asm_q, byte_data};
   assign words_d = words_q + (ADDR_W+1)'(1);

   // Loader FSM, byte assembler and registered write request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_HDR;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         hdr_q      <= '0;
         ptr_q      <= '0;
         words_q    <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            ST_HDR: begin
               if (byte_valid) begin
                  asm_q      <= word_d[23:0];
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     // Counts above DEPTH go to ERR, so ADDR_W+1 bits suffice.
                     hdr_q <= word_d[ADDR_W:0];
                     if (word_d == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end else if ({1'b0, word_d} > DEPTH) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                     end else begin
                        state_q <= ST_DATA;
                        ptr_q   <= '0;
                        words_q <= '0;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (byte_valid) begin
                  asm_q      <= word_d[23:0];
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     we_q    <= 1'b1;
                     waddr_q <= ptr_q;
                     wdata_q <= word_d;
                  end
               end
               // Bookkeeping happens on the edge that performs the write, so
               // load_done rises together with the final word landing.
               if (we_q) begin
                  ptr_q   <= ptr_q + ADDR_W'(1);
                  words_q <= words_d;
                  if (words_d == hdr_q) begin
                     state_q    <= ST_DONE;
                     done_q     <= 1'b1;
                     byte_cnt_q <= '0;
                  end
               end
            end
            ST_DONE, ST_ERR: begin
               if (reload) begin
                  state_q    <= ST_HDR;
                  byte_cnt_q <= '0;
                  words_q    <= '0;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
               end
            end
         endcase
      end
   end

   inst_bram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we_q),
      .waddr_i (waddr_q),
      .wdata_i (wdata_q),
      .re_i    (inst_enable),
      .raddr_i (inst_addr),
      .rdata_o (inst_data)
   );

   assign load_done    = done_q;
   assign load_err     = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: a byte/word-level model plus directed scenarios.
module tb_inst_mem_loader;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              rst;
   logic              inst_enable;
   logic [ADDR_W-1:0] inst_addr;
   logic [31:0]       inst_data;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              reload;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   int checks   = 0;
   int failures = 0;

   inst_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_enable  (inst_enable),
      .inst_addr    (inst_addr),
      .inst_data    (inst_data),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .reload       (reload),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem [int];
   logic [7:0]  m_bytes [$];
   bit          m_have_hdr, m_done, m_err, m_wr_pend, m_rd_known, m_idle;
   int          m_n, m_words, m_wr_addr;
   logic [31:0] m_wr_word, m_rd, m_w;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_bytes.delete();
         m_have_hdr = 0; m_done = 0; m_err = 0; m_wr_pend = 0;
         m_n = 0; m_words = 0; m_rd = '0; m_rd_known = 1;
      end else begin
         m_idle = m_done || m_err;
         if (inst_enable) begin
            m_rd_known = m_mem.exists(int'(inst_addr));
            if (m_rd_known) m_rd = m_mem[int'(inst_addr)];
         end
         if (m_wr_pend) begin
            m_mem[m_wr_addr] = m_wr_word;
            m_wr_pend = 0;
            m_words++;
            if (m_words == m_n) begin
               m_done = 1; m_have_hdr = 0; m_bytes.delete();
            end
         end
         if (m_idle) begin
            if (reload) begin
               m_done = 0; m_err = 0; m_words = 0; m_have_hdr = 0; m_bytes.delete();
            end
         end else if (!m_done && byte_valid) begin
            m_bytes.push_back(byte_data);
            if (m_bytes.size() == 4) begin
               m_w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
               m_bytes.delete();
               if (!m_have_hdr) begin
                  if (m_w == 0)                     m_done = 1;
                  else if (longint'(m_w) > DEPTH)   m_err  = 1;
                  else begin
                     m_have_hdr = 1; m_n = int'(m_w); m_words = 0;
                  end
               end else begin
                  m_wr_pend = 1; m_wr_word = m_w; m_wr_addr = m_words % DEPTH;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("model_load_done", 32'(load_done), 32'(m_done));
         chk("model_load_err", 32'(load_err), 32'(m_err));
         chk("model_words_loaded", 32'(words_loaded), 32'(m_words));
         if (m_rd_known) chk("model_inst_data", inst_data, m_rd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic idle_in();
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   initial begin
      rst = 1'b1; inst_enable = 1'b0; inst_addr = '0;
      byte_valid = 1'b0; byte_data = '0; reload = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_load_done", 32'(load_done), 32'h0);
      chk("rst_load_err", 32'(load_err), 32'h0);
      chk("rst_words", 32'(words_loaded), 32'h0);
      rst = 1'b0;

      // Two-word program, bytes back to back.
      send_word(32'h0000_0002);
      send_word(32'hdead_beef);
      send_word(32'h0123_4567);
      idle_in();
      @(negedge clk);
      chk("t1_done", 32'(load_done), 32'h1);
      chk("t1_err", 32'(load_err), 32'h0);
      chk("t1_words", 32'(words_loaded), 32'h2);

      // Back-to-back reads, then hold.
      inst_enable = 1'b1; inst_addr = 16'd0;
      @(negedge clk);
      chk("t2_rd0", inst_data, 32'hdead_beef);
      inst_addr = 16'd1;
      @(negedge clk);
      chk("t2_rd1", inst_data, 32'h0123_4567);
      inst_enable = 1'b0; inst_addr = 16'd0;
      @(negedge clk);
      chk("t2_hold", inst_data, 32'h0123_4567);

      // Empty program.
      pulse_reload();
      chk("t3_done_clr", 32'(load_done), 32'h0);
      send_word(32'h0);
      idle_in();
      chk("t3_done", 32'(load_done), 32'h1);
      chk("t3_words", 32'(words_loaded), 32'h0);

      // Oversized header; later bytes ignored.
      pulse_reload();
      send_word(32'h0001_0001);
      send_word(32'h1111_1111);
      idle_in();
      chk("t4_err", 32'(load_err), 32'h1);
      chk("t4_done", 32'(load_done), 32'h0);
      chk("t4_words", 32'(words_loaded), 32'h0);

      // Read-first collision on mem[0].
      pulse_reload();
      send_word(32'h0000_0001);
      send_word(32'hcafe_f00d);
      @(negedge clk);
      byte_valid = 1'b0; inst_enable = 1'b1; inst_addr = 16'd0;
      @(negedge clk);
      chk("t5_read_old", inst_data, 32'hdead_beef);
      chk("t5_done", 32'(load_done), 32'h1);
      @(negedge clk);
      chk("t5_read_new", inst_data, 32'hcafe_f00d);
      inst_enable = 1'b0;

      // Full-depth header is legal; abort with reset after 1.5 words.
      pulse_reload();
      send_word(32'h0001_0000);
      send_word(32'ha1a2_a3a4);
      send_byte(8'hb1);
      send_byte(8'hb2);
      idle_in();
      chk("t6_err", 32'(load_err), 32'h0);
      chk("t6_words", 32'(words_loaded), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_data", inst_data, 32'h0);
      chk("t6_rst_words", 32'(words_loaded), 32'h0);
      chk("t6_rst_done", 32'(load_done), 32'h0);
      #1 rst = 1'b0;
      @(negedge clk);
      inst_enable = 1'b1; inst_addr = 16'd0;
      @(negedge clk);
      chk("t6_mem_kept", inst_data, 32'ha1a2_a3a4);
      inst_enable = 1'b0;
      send_word(32'h0000_0001);
      send_word(32'h1122_3344);
      idle_in();
      @(negedge clk);
      chk("t6_fresh_done", 32'(load_done), 32'h1);
      inst_enable = 1'b1;
      @(negedge clk);
      chk("t6_fresh_rd", inst_data, 32'h1122_3344);
      inst_enable = 1'b0;

      // Reload from DONE with a single word.
      pulse_reload();
      chk("t7_done_clr", 32'(load_done), 32'h0);
      chk("t7_words_clr", 32'(words_loaded), 32'h0);
      send_word(32'h0000_0001);
      send_word(32'h0000_000c);
      idle_in();
      chk("t7_done_pre", 32'(load_done), 32'h0);
      @(negedge clk);
      chk("t7_done", 32'(load_done), 32'h1);
      chk("t7_words", 32'(words_loaded), 32'h1);
      inst_enable = 1'b1;
      @(negedge clk);
      chk("t7_rd", inst_data, 32'h0000_000c);
      inst_enable = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Responder side of the core's instruction-fetch port: a synchronous instruction memory that answers inst_enable/inst_addr with inst_data one cycle later.
It also contains a boot loader that assembles a byte stream from the UART receiver into 32-bit words and writes them from address 0 upward.
It asserts load_done when the program is in place, which releases the core from reset-hold.
It sits between the UART receiver and the fetch stage.

Parameters:
ADDR_W, 16, word-address width; memory depth is 2**ADDR_W words
DATA_W, 32, instruction word width; fixed at 32, not to be overridden

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
inst_enable  input  1  read strobe from fetch
inst_addr  input  ADDR_W  word address from fetch
inst_data  output  32  registered read data
byte_valid  input  1  one-cycle pulse: byte_data valid (UART receiver)
byte_data  input  8  received byte
reload  input  1  pulse; restart loading from DONE/ERR
load_done  output  1  level; program fully written
load_err  output  1  level; header word count exceeds depth
words_loaded  output  ADDR_W+1  words written so far in the current load

Behaviour:
- Reset (async, rst=1):
  - inst_data=0, load_done=0, load_err=0, words_loaded=0.
  - FSM goes to HDR, byte counter 0, header register 0.
  - Memory array contents are not cleared.
- Read port:
  - If inst_enable is high at edge N, inst_data at edge N+1 = mem[inst_addr]. Latency is exactly 1.
  - If inst_enable is low, inst_data holds its value.
  - Reads are served in every state.
  - A read and a write to the same address in the same cycle is read-first: inst_data returns the old word.
- Byte assembly:
  - Big-endian; the first byte of each group lands in bits[31:24].
  - A 2-bit byte counter wraps 3→0 and is reset to 0 on every state entry.
  - byte_valid is ignored in DONE and ERR.
- FSM states HDR, DATA, DONE, ERR:
  - HDR: collect 4 bytes into the header register (word count N).
    - On the 4th byte with N==0: go to DONE; load_done=1 next cycle.
    - With N>2**ADDR_W: go to ERR; load_err=1.
    - Otherwise go to DATA and set the write pointer to 0.
  - DATA: on each 4th byte, the assembled word is written to mem[ptr] on the following edge (write is registered). Then ptr++ and words_loaded++.
    - When words_loaded reaches N after a write, go to DONE.
    - load_done rises on the same edge as the final write, so it is visible one cycle after that edge.
  - DONE: load_done=1; hold.
  - ERR: load_err=1; hold.
  - From DONE or ERR, reload=1: go to HDR; clear load_done, load_err, words_loaded.
  - reload in HDR or DATA is ignored.
- Boundary rules:
  - N==2**ADDR_W is legal. ptr wraps to 0 after the last write but is never used again.
  - byte_valid on consecutive cycles must be accepted without loss, one byte per cycle.
  - Reset mid-load: words already written stay in memory; the FSM restarts at HDR.
- Memory must infer block RAM: a single synchronous write port and a single synchronous read port, with no reset on the array.

Decomposition:
- Shared package: FSM state encoding (HDR=2'd0, DATA=2'd1, DONE=2'd2, ERR=2'd3) and the INST_DATA_W=32 constant.
- Package also holds the NOP word (32'h0), shared with the fetch stage's bubble handling.
- One natural sub-module: inst_bram, a 1R1W read-first synchronous RAM. The loader FSM and byte assembler stay in the top.

Test Plan:
- Reset, then bytes 00 00 00 02, DE AD BE EF, 01 23 45 67 → mem[0]=32'hdeadbeef, mem[1]=32'h01234567, words_loaded=2, load_done=1, load_err=0.
- After load, inst_enable=1 with addr 0 then addr 1 on back-to-back cycles → inst_data=deadbeef on edge+1, then 01234567 on the next edge. Drop inst_enable → inst_data holds 01234567.
- Header 00 00 00 00 → DONE within 1 cycle of the 4th byte, words_loaded=0. Header 00 01 00 01 with ADDR_W=16 → load_err=1, and later data bytes are ignored.
- Read-first collision: during DATA, fetch reads addr 0 on the same cycle the loader writes mem[0] → inst_data returns the pre-write value; the next read returns the new value.
- Assert rst for 1 cycle asynchronously after 1.5 words of a 3-word load → outputs 0 immediately, mem[0] retained, and a fresh header is accepted.
- From DONE, pulse reload, then load 1 word 0x0000000c → load_done falls the cycle after reload and rises after the write, mem[0]=0000000c, words_loaded=1.
